// File: rtl/ws2811_pixel_serializer.sv
// Serializes 24-bit GRB pixels MSB-first into fixed-length bit slots for the WS2811 encoder,
// then holds the line low for the latch period.  state | meaning: IDLE wait | FETCH first pixel | SHIFT bits | LATCH low
module ws2811_pixel_serializer #(
  parameter int BIT_CYCLES   = 126,
  parameter int NUM_LEDS     = 50,
  parameter int RESET_CYCLES = 2600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        data,
  output logic        select,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int CYC_W = $clog2(BIT_CYCLES);
  localparam int LED_W = $clog2(NUM_LEDS + 1);
  localparam int LAT_W = $clog2(RESET_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_LATCH} state_t;

  state_t             state_q, state_d;
  logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [LED_W-1:0]   led_cnt_q, led_cnt_d;
  logic [LED_W-1:0]   fetch_cnt_q, fetch_cnt_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [23:0]        shreg_q, shreg_d;
  logic [23:0]        hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               pix_ready_q, pix_ready_d;
  logic               frame_done_q, frame_done_d;
  logic               xfer;
  logic               slot_end;
  logic               boundary;

  assign xfer     = pix_valid && pix_ready_q;
  assign slot_end = (cyc_cnt_q == CYC_W'(BIT_CYCLES - 1));
  assign boundary = (state_q == S_SHIFT) && slot_end && (bit_cnt_q == 5'd23);

  always_comb begin
    state_d      = state_q;
    cyc_cnt_d    = cyc_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    led_cnt_d    = led_cnt_q;
    fetch_cnt_d  = fetch_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    shreg_d      = shreg_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    frame_done_d = 1'b0;
    underrun     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d     = S_FETCH;
          led_cnt_d   = '0;
          fetch_cnt_d = '0;
        end
      end
      S_FETCH: begin
        if (xfer) begin
          shreg_d     = pix_data;
          fetch_cnt_d = fetch_cnt_q + LED_W'(1);
          cyc_cnt_d   = '0;
          bit_cnt_d   = '0;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // A transfer outside the boundary cycle parks the pixel in the holding register.
        if (xfer && !boundary) begin
          hold_d      = pix_data;
          hold_full_d = 1'b1;
          fetch_cnt_d = fetch_cnt_q + LED_W'(1);
        end
        if (!slot_end) begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end else if (bit_cnt_q != 5'd23) begin
          cyc_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 5'd1;
          shreg_d   = {shreg_q[22:0], 1'b0};
        end else begin
          cyc_cnt_d = '0;
          bit_cnt_d = '0;
          led_cnt_d = led_cnt_q + LED_W'(1);
          if (led_cnt_q == LED_W'(NUM_LEDS - 1)) begin
            state_d   = S_LATCH;
            lat_cnt_d = '0;
          end else if (hold_full_q) begin
            shreg_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            shreg_d     = pix_data;
            fetch_cnt_d = fetch_cnt_q + LED_W'(1);
          end else begin
            underrun  = 1'b1;
            state_d   = S_LATCH;
            lat_cnt_d = '0;
          end
        end
      end
      S_LATCH: begin
        if (lat_cnt_q == LAT_W'(RESET_CYCLES - 1)) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    pix_ready_d = !hold_full_d && (fetch_cnt_d < LED_W'(NUM_LEDS)) &&
                  ((state_d == S_FETCH) || (state_d == S_SHIFT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cyc_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      led_cnt_q    <= '0;
      fetch_cnt_q  <= '0;
      lat_cnt_q    <= '0;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      pix_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_cnt_q    <= cyc_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      led_cnt_q    <= led_cnt_d;
      fetch_cnt_q  <= fetch_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      pix_ready_q  <= pix_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign select     = (state_q == S_SHIFT);
  assign data       = select && shreg_q[23];
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2811_pixel_serializer.sv
// Directed bench for ws2811_pixel_serializer with a small geometry (2 LEDs, 4-cycle bits, 8-cycle latch).
module tb_ws2811_pixel_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        data;
  logic        select;
  logic        busy;
  logic        frame_done;
  logic        underrun;

  int n_checks = 0;
  int n_err    = 0;

  ws2811_pixel_serializer #(
    .BIT_CYCLES  (4),
    .NUM_LEDS    (2),
    .RESET_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .data       (data),
    .select     (select),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: always valid; 1: second pixel withheld (underrun);
  // 2: second pixel valid only in boundary cycle; 3: frame_start pokes mid-SHIFT and mid-LATCH.
  task automatic run_frame(input logic [23:0] p0, input logic [23:0] p1, input int mode);
    int          nshift;
    logic [23:0] px;
    logic        eb;
    nshift = (mode == 1) ? 96 : 192;
    frame_start = 1'b1; pix_valid = 1'b1; pix_data = p0;
    #1;
    chk("idle_select", select, 0);
    tick();
    frame_start = 1'b0;
    #1;
    chk("fetch_ready", pix_ready, 1);
    chk("fetch_busy", busy, 1);
    chk("fetch_select", select, 0);
    tick();
    for (int k = 0; k < nshift; k++) begin
      pix_data    = p1;
      pix_valid   = (mode == 0 || mode == 3) ? 1'b1 : ((mode == 2) && (k == 95));
      frame_start = (mode == 3) && (k == 50);
      #1;
      px = (k < 96) ? p0 : p1;
      eb = px[23 - (k % 96) / 4];
      chk("shift_select", select, 1);
      chk("shift_data", data, eb);
      chk("shift_busy", busy, 1);
      chk("shift_underrun", underrun, (mode == 1) && (k == 95));
      if (mode == 1 && k == 10) chk("withheld_ready", pix_ready, 1);
      if (mode == 2 && k == 95) chk("bypass_ready", pix_ready, 1);
      if (mode == 0 && k == 20) chk("full_hold_ready", pix_ready, 0);
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      pix_valid   = (mode == 1);
      frame_start = (mode == 3) && (j == 3);
      #1;
      chk("latch_select", select, 0);
      chk("latch_data", data, 0);
      chk("latch_busy", busy, 1);
      chk("latch_done", frame_done, 0);
      chk("latch_ready", pix_ready, 0);
      tick();
    end
    frame_start = 1'b0; pix_valid = 1'b0;
    #1;
    chk("frame_done_pulse", frame_done, 1);
    chk("done_busy", busy, 0);
    chk("done_select", select, 0);
    tick();
    #1;
    chk("frame_done_clear", frame_done, 0);
    chk("after_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_select", select, 0);
      chk("rst_data", data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", pix_ready, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_underrun", underrun, 0);
    end

    run_frame(24'hA50000, 24'h0000FF, 0);
    repeat (2) tick();
    run_frame(24'hA50000, 24'h0000FF, 1);
    repeat (2) tick();
    run_frame(24'hC30081, 24'h5A0F3C, 2);
    repeat (2) tick();
    run_frame(24'h81FF18, 24'h0000FF, 3);
    repeat (2) tick();

    frame_start = 1'b1; pix_valid = 1'b1; pix_data = 24'hA50000;
    tick();
    frame_start = 1'b0;
    repeat (20) tick();
    #1;
    chk("pre_rst_select", select, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; pix_valid = 1'b0;
    #1;
    chk("abort_select", select, 0);
    chk("abort_data", data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", pix_ready, 0);
    chk("abort_done", frame_done, 0);
    chk("abort_underrun", underrun, 0);
    repeat (2) tick();
    run_frame(24'hA50000, 24'h0000FF, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
